// File: rtl/matmul_apb_slave.sv
// APB register slave for a matrix-multiply core: control, operand lines, flags and scratchpad
// read-through. Define MATMUL_APB_PSLVERR_EN to flag dropped writes and misaligned accesses.
module matmul_apb_slave #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned MAX_DIM    = 4,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             psel_i,
    input  logic                             penable_i,
    input  logic                             pwrite_i,
    input  logic [MAX_DIM-1:0]               pstrb_i,
    input  logic [BUS_WIDTH-1:0]             pwdata_i,
    input  logic [ADDR_WIDTH-1:0]            paddr_i,
    output logic                             pready_o,
    output logic                             pslverr_o,
    output logic [BUS_WIDTH-1:0]             prdata_o,
    input  logic                             busy_i,
    input  logic [BUS_WIDTH-1:0]             flags_i,
    output logic                             start_o,
    output logic [15:0]                      control_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]     operand_a_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]     operand_b_o,
    output logic                             sp_rd_o,
    output logic [2+2*$clog2(MAX_DIM)-1:0]   sp_addr_o,
    input  logic [BUS_WIDTH-1:0]             sp_rdata_i
);
    localparam int unsigned LineW    = $clog2(MAX_DIM);
    localparam int unsigned SpIdxW   = 2 * LineW;
    localparam logic [15:0] CtrlMask = 16'h3F3E;

    typedef enum logic [1:0] {StIdle, StAccess, StSpWait} state_e;

    state_e                       state_q, state_d;
    logic [15:0]                  control_q, control_d;
    logic [MAX_DIM*BUS_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic                         start_q, start_d;

    logic                 aligned, is_ctrl, is_opa, is_opb, is_flags, is_sp;
    logic [LineW-1:0]     line_idx;
    logic [BUS_WIDTH-1:0] wmask, ctrl_merged, line_a, line_b, rdata;
    logic                 access, sp_read, fast_done, wr_drop, wr_ok;
    logic                 unused_bits;

    assign aligned  = (paddr_i[1:0] == 2'b00);
    assign is_ctrl  = aligned && (paddr_i[4:2] == 3'd0);
    assign is_opa   = aligned && (paddr_i[4:2] == 3'd1);
    assign is_opb   = aligned && (paddr_i[4:2] == 3'd2);
    assign is_flags = aligned && (paddr_i[4:2] == 3'd3);
    assign is_sp    = aligned && paddr_i[4];
    assign line_idx = paddr_i[5 +: LineW];

    // Each strobe bit enables one operand element lane.
    for (genvar g = 0; g < MAX_DIM; g++) begin : g_strb
        assign wmask[g*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{pstrb_i[g]}};
    end

    assign line_a      = opa_q[line_idx*BUS_WIDTH +: BUS_WIDTH];
    assign line_b      = opb_q[line_idx*BUS_WIDTH +: BUS_WIDTH];
    assign ctrl_merged = (BUS_WIDTH'(control_q) & ~wmask) | (pwdata_i & wmask);

    assign access    = (state_q == StAccess) && psel_i && penable_i;
    assign sp_read   = access && !pwrite_i && is_sp;
    assign fast_done = access && !sp_read;
    assign wr_drop   = !aligned || is_flags || is_sp || busy_i;
    assign wr_ok     = fast_done && pwrite_i && !wr_drop;

    always_comb begin
        rdata = '0;
        if (is_ctrl) begin
            rdata = BUS_WIDTH'(control_q);
        end else if (is_opa) begin
            rdata = line_a;
        end else if (is_opb) begin
            rdata = line_b;
        end else if (is_flags) begin
            rdata = flags_i;
        end
    end

    always_comb begin
        pready_o = fast_done || (state_q == StSpWait);
        prdata_o = '0;
        if (state_q == StSpWait) begin
            prdata_o = sp_rdata_i;
        end else if (fast_done && !pwrite_i) begin
            prdata_o = rdata;
        end
    end

`ifdef MATMUL_APB_PSLVERR_EN
    assign pslverr_o = fast_done && (!aligned || (pwrite_i && wr_drop));
`else
    assign pslverr_o = 1'b0;
`endif

    assign sp_rd_o     = sp_read;
    assign sp_addr_o   = {paddr_i[3:2], paddr_i[5 +: SpIdxW]};
    assign start_o     = start_q;
    assign control_o   = control_q;
    assign operand_a_o = opa_q;
    assign operand_b_o = opb_q;
    assign unused_bits = ^{paddr_i[ADDR_WIDTH-1:5+SpIdxW], ctrl_merged[BUS_WIDTH-1:16]};

    always_comb begin
        state_d   = state_q;
        control_d = control_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        start_d   = 1'b0;
        unique case (state_q)
            StIdle:   if (psel_i) state_d = StAccess;
            // A dropped penable also lands here, aborting without side effects.
            StAccess: state_d = sp_read ? StSpWait : StIdle;
            StSpWait: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (wr_ok) begin
            if (is_ctrl) begin
                control_d = ctrl_merged[15:0] & CtrlMask;
                start_d   = pstrb_i[0] & pwdata_i[0];
            end
            if (is_opa) begin
                opa_d[line_idx*BUS_WIDTH +: BUS_WIDTH] = (line_a & ~wmask) | (pwdata_i & wmask);
            end
            if (is_opb) begin
                opb_d[line_idx*BUS_WIDTH +: BUS_WIDTH] = (line_b & ~wmask) | (pwdata_i & wmask);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            control_q <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            control_q <= control_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            start_q   <= start_d;
        end
    end

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Self-checking bench for matmul_apb_slave: directed cases plus randomized APB traffic
// against a register-map model.
module tb_matmul_apb_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]  pstrb = '0;
    logic [31:0] pwdata = '0;
    logic [15:0] paddr = '0;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        busy = 1'b0;
    logic [31:0] flags = '0;
    logic        start;
    logic [15:0] control;
    logic [127:0] opa_o, opb_o;
    logic        sp_rd;
    logic [5:0]  sp_addr;
    logic [31:0] sp_rdata = '0;

    always #5 clk = ~clk;

    matmul_apb_slave #(
        .DATA_WIDTH(8), .BUS_WIDTH(32), .MAX_DIM(4), .ADDR_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite), .pstrb_i(pstrb),
        .pwdata_i(pwdata), .paddr_i(paddr),
        .pready_o(pready), .pslverr_o(pslverr), .prdata_o(prdata),
        .busy_i(busy), .flags_i(flags), .start_o(start), .control_o(control),
        .operand_a_o(opa_o), .operand_b_o(opb_o),
        .sp_rd_o(sp_rd), .sp_addr_o(sp_addr), .sp_rdata_i(sp_rdata)
    );

`ifdef MATMUL_APB_PSLVERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // Register-map model
    logic [31:0] m_ctrl;
    logic [31:0] m_opa [4];
    logic [31:0] m_opb [4];
    logic        m_start = 1'b0;
    logic        start_req = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_ctrl = '0;
        for (int i = 0; i < 4; i++) begin
            m_opa[i] = '0;
            m_opb[i] = '0;
        end
        m_start   = 1'b0;
        start_req = 1'b0;
    endtask

    // Start pulse is visible during the cycle following the write edge.
    always @(posedge clk) begin
        #1;
        m_start   = start_req;
        start_req = 1'b0;
    end

    always @(negedge clk) begin
        chk("operand_a", opa_o, {m_opa[3], m_opa[2], m_opa[1], m_opa[0]});
        chk("operand_b", opb_o, {m_opb[3], m_opb[2], m_opb[1], m_opb[0]});
        chk("control", 128'(control), 128'(m_ctrl[15:0]));
        chk("start", 128'(start), 128'(m_start));
    end

    task automatic apb_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic bsy, output logic err_seen);
        int  word;
        bit  drop;
        word = int'(addr[4:2]);
        drop = (addr[1:0] != 2'b00) || (word >= 3) || bsy;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = addr; pwdata = data; pstrb = strb; busy = bsy;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("wr_pready", 128'(pready), 128'(1));
        chk("wr_pslverr", 128'(pslverr), 128'(ErrEn && drop));
        chk("wr_prdata", 128'(prdata), 128'(0));
        err_seen = pslverr;
        @(posedge clk);
        if (!drop) begin
            if (word == 0) begin
                m_ctrl    = merge(m_ctrl, data, strb) & 32'h0000_3F3E;
                start_req = strb[0] & data[0];
            end
            if (word == 1) m_opa[addr[6:5]] = merge(m_opa[addr[6:5]], data, strb);
            if (word == 2) m_opb[addr[6:5]] = merge(m_opb[addr[6:5]], data, strb);
        end
        #1;
        psel = 1'b0; penable = 1'b0; busy = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] addr, input logic [31:0] flg,
                            input logic [31:0] spd, output logic [31:0] got,
                            output logic [5:0] spa);
        int          word;
        bit          mis;
        logic [31:0] exp;
        word = int'(addr[4:2]);
        mis  = (addr[1:0] != 2'b00);
        spa  = '0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr; flags = flg;
        @(posedge clk); #1;
        penable = 1'b1;
        if (!mis && word >= 4) begin
            @(negedge clk);
            chk("sp_rd", 128'(sp_rd), 128'(1));
            chk("sp_addr", 128'(sp_addr), 128'({2'(word - 4), addr[8:5]}));
            chk("sp_wait_pready", 128'(pready), 128'(0));
            chk("sp_wait_prdata", 128'(prdata), 128'(0));
            spa = sp_addr;
            @(posedge clk); #1;
            sp_rdata = spd;
            @(negedge clk);
            chk("sp_pready", 128'(pready), 128'(1));
            chk("sp_prdata", 128'(prdata), 128'(spd));
            chk("sp_rd_drop", 128'(sp_rd), 128'(0));
            chk("sp_pslverr", 128'(pslverr), 128'(0));
        end else begin
            exp = '0;
            if (!mis) begin
                case (word)
                    0:       exp = m_ctrl;
                    1:       exp = m_opa[addr[6:5]];
                    2:       exp = m_opb[addr[6:5]];
                    default: exp = flg;
                endcase
            end
            @(negedge clk);
            chk("rd_pready", 128'(pready), 128'(1));
            chk("rd_prdata", 128'(prdata), 128'(exp));
            chk("rd_pslverr", 128'(pslverr), 128'(ErrEn && mis));
            chk("rd_sp_rd", 128'(sp_rd), 128'(0));
        end
        got = prdata;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        err;
        logic [31:0] got;
        logic [5:0]  spa;
        logic [6:0]  hi;
        logic [3:0]  idx;
        logic [2:0]  wd;
        logic [1:0]  mis;

        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_pready", 128'(pready), 128'(0));
        chk("reset_prdata", 128'(prdata), 128'(0));
        chk("reset_pslverr", 128'(pslverr), 128'(0));
        chk("reset_sp_rd", 128'(sp_rd), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        apb_write(16'h0044, 32'h0403_0201, 4'b1111, 1'b0, err);
        chk("opa_line2_lit", 128'(opa_o[95:64]), 128'(32'h0403_0201));
        apb_write(16'h0028, 32'hAABB_CCDD, 4'b0101, 1'b0, err);
        chk("opb_line1_lit", 128'(opb_o[63:32]), 128'(32'h00BB_00DD));

        apb_write(16'h0000, 32'h0000_3F03, 4'b1111, 1'b0, err);
        chk("start_pulse_lit", 128'(start), 128'(1));
        @(posedge clk); #1;
        chk("start_once_lit", 128'(start), 128'(0));
        apb_read(16'h0000, 32'h0, 32'h0, got, spa);
        chk("ctrl_read_lit", 128'(got), 128'(32'h0000_3F02));

        apb_write(16'h0000, 32'h0000_FFFF, 4'b0000, 1'b0, err);
        chk("strb0_ctrl_lit", 128'(control), 128'(16'h3F02));

        apb_read(16'h00B8, 32'h0, 32'hFFFF_FFF6, got, spa);
        chk("sp_addr_lit", 128'(spa), 128'(6'b10_0101));
        chk("sp_data_lit", 128'(got), 128'(32'hFFFF_FFF6));

        apb_write(16'h0004, 32'h1234_5678, 4'b1111, 1'b1, err);
        chk("busy_drop_lit", 128'(opa_o[31:0]), 128'(0));
        chk("busy_err_lit", 128'(err), 128'(ErrEn));

        // Abandoned transfer: penable never rises.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0004;
        pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_pready", 128'(pready), 128'(0));
        @(posedge clk); #1;
        psel = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_write", 128'(opa_o[31:0]), 128'(0));

        // Reset while waiting on the scratchpad.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0010;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_pready", 128'(pready), 128'(0));
        chk("rst_prdata", 128'(prdata), 128'(0));
        chk("rst_sp_rd", 128'(sp_rd), 128'(0));
        chk("rst_pslverr", 128'(pslverr), 128'(0));
        chk("rst_outputs", {control, start, opa_o[31:0], opb_o[31:0]}, 128'(0));
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apb_read(16'h0000, 32'h0, 32'h0, got, spa);
        chk("post_rst_ctrl_lit", 128'(got), 128'(0));

        for (int n = 0; n < 300; n++) begin
            hi  = 7'($urandom_range(0, 127));
            idx = 4'($urandom_range(0, 15));
            wd  = 3'($urandom_range(0, 7));
            mis = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 1) == 1) begin
                apb_write({hi, idx, wd, mis}, $urandom, 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0), err);
            end else begin
                apb_read({hi, idx, wd, mis}, $urandom, $urandom, got, spa);
            end
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
